// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register, ARM condition evaluation and write-enable gating
module cond_flag_unit #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_i,
   input  logic       stall_i,
   input  logic [3:0] cond_i,
   input  logic [1:0] flag_write_i,
   input  logic [3:0] alu_flags_i,
   input  logic       pc_src_i,
   input  logic       reg_write_i,
   input  logic       mem_write_i,
   output logic       cond_ex_o,
   output logic       pc_src_o,
   output logic       reg_write_o,
   output logic       mem_write_o,
   output logic [3:0] flags_o
);

   logic [3:0] flags_q;
   logic [3:0] flags_d;
   logic       cond_pass;
   logic       flag_n;
   logic       flag_z;
   logic       flag_c;
   logic       flag_v;
   logic       update_en;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Evaluate the condition field against the flags as they stood before this instruction
   always_comb begin
      cond_pass = 1'b0;
      case (cond_i)
         4'h0:    cond_pass = flag_z;
         4'h1:    cond_pass = ~flag_z;
         4'h2:    cond_pass = flag_c;
         4'h3:    cond_pass = ~flag_c;
         4'h4:    cond_pass = flag_n;
         4'h5:    cond_pass = ~flag_n;
         4'h6:    cond_pass = flag_v;
         4'h7:    cond_pass = ~flag_v;
         4'h8:    cond_pass = flag_c & ~flag_z;
         4'h9:    cond_pass = ~flag_c | flag_z;
         4'hA:    cond_pass = (flag_n == flag_v);
         4'hB:    cond_pass = (flag_n != flag_v);
         4'hC:    cond_pass = ~flag_z & (flag_n == flag_v);
         4'hD:    cond_pass = flag_z | (flag_n != flag_v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Enables are qualified by the condition; reset and bubbles suppress everything
   assign cond_ex_o   = cond_pass & valid_i & ~reset;
   assign pc_src_o    = pc_src_i & cond_ex_o;
   assign reg_write_o = reg_write_i & cond_ex_o;
   assign mem_write_o = mem_write_i & cond_ex_o;

   assign update_en = valid_i & cond_ex_o & ~stall_i;

   // Next flag value: NZ and CV groups update independently, otherwise hold
   always_comb begin
      flags_d = flags_q;
      if (update_en && flag_write_i[1]) begin
         flags_d[3:2] = alu_flags_i[3:2];
      end
      if (update_en && flag_write_i[0]) begin
         flags_d[1:0] = alu_flags_i[1:0];
      end
   end

   // Flag register; reset takes priority over any pending update
   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q <= RESET_FLAGS;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o = flags_q;

endmodule
